core_reset_seq: RTL
===================

// Module: core_reset_seq
// PURPOSE
//  Parametrised reset/RAM-clear sequencer for arcade core tops; replaces ad-hoc OSD-reset/clr_addr logic.
//  Merges NSRC reset requests (OSD status bit, menu button, board keys, player buttons) into one core reset.
//  Sweeps a clear address over work RAM before releasing reset. Latches which source caused the sequence.
// PARAMETERS
//  CLR_AW      17      clear-address width; a sweep is 2**CLR_AW write cycles
//  NSRC        4       number of reset request inputs
//  SRC_ACT_LOW 4'b0000 per-source polarity mask; bit=1 means source active-low (e.g. board KEY)
//  HOLD_CYCLES 16      reset-hold cycles after sweep (>=1)
//  DB_BITS     16      debounce counter width (used only with CORE_RSTSEQ_DEBOUNCE_EN)
// PORTS
//  clk        in   1        core clock (PLL output)
//  reset      in   1        asynchronous, active-high; power-on / PLL-not-locked
//  src_req    in   NSRC     asynchronous reset requests, level-sensitive, polarity per SRC_ACT_LOW
//  core_reset out  1        active-high reset to core logic
//  core_rst_n out  1        registered inverse of core_reset (for active-low cores)
//  clr_addr   out  CLR_AW   RAM clear address
//  clr_we     out  1        RAM clear write strobe (write zero at clr_addr)
//  busy       out  1        1 in CLEAR or HOLD
//  done       out  1        one-cycle pulse when core_reset deasserts
//  cause      out  NSRC+1   sticky cause: bit NSRC = power-on, bit i = src_req[i]
// BEHAVIOUR
//  Reset values (async, reset=1): state=CLEAR, clr_addr=0, clr_we=0, core_reset=1, core_rst_n=0,
//   busy=1, done=0, cause={1'b1,NSRC'b0}, hold counter=0, synchronisers/debouncers cleared.
//  Input path: each src_req XOR SRC_ACT_LOW, then 2-flop synchroniser -> qualified req q[i]; any_q = |q.
//  States:
//   CLEAR: clr_we=1, clr_addr increments by 1 per clk. If any_q: clr_addr held at 0, clr_we=1.
//          When clr_addr all-ones is written and any_q=0 -> HOLD, cnt=HOLD_CYCLES-1, clr_we=0.
//   HOLD : core_reset=1; cnt decrements. any_q -> CLEAR, clr_addr=0.
//          cnt==0 -> RUN; on that edge core_reset=0, core_rst_n=1, busy=0, done=1 for one cycle.
//   RUN  : all outputs idle (clr_we=0, clr_addr=0). any_q -> CLEAR, clr_addr=0, core_reset=1 same edge.
//          On RUN->CLEAR, cause cleared then loaded with q.
//  cause: in CLEAR/HOLD, cause |= q each cycle (sticky until next RUN->CLEAR); readable in RUN.
//  Latency, no debounce: src_req edge -> core_reset=1 on 3rd clk edge (2 sync + 1 state reg).
//  Sweep timing from reset release: edges 1..2**CLR_AW write addr 0..max;
//   core_reset falls on edge 2**CLR_AW+HOLD_CYCLES.
//  clr_addr wraps never: sweep ends at all-ones; held request pins addr 0 (restart, no partial resume).
//  Simultaneous: request on the same edge as HOLD cnt==0 wins -> CLEAR, no done pulse.
//  Async reset mid-sweep: immediate return to reset values; cause shows power-on only.
//  All outputs registered; no combinational path from src_req to any output.
// CONFIGURATION
//  CORE_RSTSEQ_DEBOUNCE_EN defined: after sync, each source passes a debouncer.
//   q[i] changes only after the synced level has been stable for 2**DB_BITS consecutive clks.
//   Any glitch restarts that source's counter. Debouncer counters reset to 0 with q[i]=0.
//  Undefined: no debouncers; q[i] = synchroniser output; DB_BITS ignored.
// TESTING
//  (params CLR_AW=4, NSRC=4, HOLD_CYCLES=3, SRC_ACT_LOW=4'b1000, DB_BITS=3 where relevant)
//  T1 power-on: release reset -> clr_we=1 addr 0..15 on edges 1..16; core_reset=0 + done on edge 19; cause=5'b10000.
//  T2 OSD request: in RUN pulse src_req[0] 1 clk -> core_reset=1 on 3rd edge; full sweep; cause=5'b00001.
//  T3 held request: hold src_req[1] 10 clks mid-sweep -> clr_addr stuck at 0 during hold; 16-write sweep restarts after release.
//  T4 active-low key: drive src_req[3]=0 in RUN -> sequence runs, cause[3]=1; src_req[3]=1 idle -> no reset.
//  T5 race: assert src_req[2] so q rises on HOLD cnt==0 edge -> no done pulse; state CLEAR, addr 0.
//  T6 debounce (macro on): 5-clk glitch on src_req[0] -> no reset; 12-clk level -> reset after 2+8 stable clks.
//  T7 async reset asserted mid-HOLD -> all outputs at reset values same cycle; cause=5'b10000.

Source files
------------

// File: rtl/core_reset_seq.sv
// core_reset_seq: reset / work-RAM clear sequencer for arcade core tops.
//
// Merges NSRC level-sensitive reset requests (OSD bit, menu button, board
// keys, player buttons) with the power-on reset. A request sweeps a clear
// address over the whole work RAM, then holds the core in reset for
// HOLD_CYCLES more edges before releasing it. The source that caused the
// sequence is latched in a sticky cause vector (bit NSRC = power-on).
//
// Sequence from reset release (N = 2**CLR_AW):
//   edges 1..N           clr_we=1, clr_addr = 0..N-1
//   edge  N              state moves to HOLD (the last write is still shown)
//   edge  N+HOLD_CYCLES  core_reset falls, done pulses for one cycle
// Any qualified request during CLEAR or HOLD pins the sweep back to address 0
// (a restart, never a partial resume). A request that arrives on the edge
// that would release reset wins: no done pulse, back to CLEAR at address 0.
//
// Optional feature (compile-time macro):
//   CORE_RSTSEQ_DEBOUNCE_EN  each synchronised request passes a debouncer;
//                            q[i] follows the synced level only after it has
//                            been stable for 2**DB_BITS consecutive clocks.
//                            Undefined: q[i] is the synchroniser output.
//
// All outputs are registered; there is no combinational path from src_req
// to any output. dbg_state exposes the FSM state for checkers.

module core_reset_seq #(
  parameter int              CLR_AW      = 17,
  parameter int              NSRC        = 4,
  parameter logic [NSRC-1:0] SRC_ACT_LOW = '0,
  parameter int              HOLD_CYCLES = 16,
  parameter int              DB_BITS     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   src_req,
  output logic              core_reset,
  output logic              core_rst_n,
  output logic [CLR_AW-1:0] clr_addr,
  output logic              clr_we,
  output logic              busy,
  output logic              done,
  output logic [NSRC:0]     cause,
  output logic [1:0]        dbg_state
);

  // ---------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Hold counter only needs to hold HOLD_CYCLES-1.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  // Address shown on the cycle before the final (all-ones) write.
  localparam logic [CLR_AW-1:0] ADDR_PENULT = ~(CLR_AW'(1));

  // ---------------------------------------------------------------------
  // Input qualification: polarity fix, 2-flop synchroniser, optional debounce
  // ---------------------------------------------------------------------
  logic [NSRC-1:0] sync1_q;
  logic [NSRC-1:0] sync2_q;
  logic [NSRC-1:0] q;
  logic            any_q;

  // Bring the asynchronous requests into the clk domain, active-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_req ^ SRC_ACT_LOW;
      sync2_q <= sync1_q;
    end
  end

`ifdef CORE_RSTSEQ_DEBOUNCE_EN
  logic [DB_BITS-1:0] db_cnt_q [NSRC];
  logic [DB_BITS-1:0] db_cnt_d [NSRC];
  logic [NSRC-1:0]    db_q;
  logic [NSRC-1:0]    db_d;

  // Per source: count consecutive clocks the synced level differs from the
  // debounced level; any return to the old level restarts the count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NSRC; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == {DB_BITS{1'b1}}) begin
        db_d[i]     = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_BITS'(1);
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q <= '0;
      for (int i = 0; i < NSRC; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < NSRC; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign q = db_q;
`else
  // DB_BITS has no effect in this build; the bypass sits in a generate so the
  // parameter list stays identical between builds.
  if (DB_BITS >= 0) begin : g_db_bypass
    assign q = sync2_q;
  end
`endif

  assign any_q = |q;

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  state_e            state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [CLR_AW-1:0] clr_addr_q,   clr_addr_d;
  logic              clr_we_q,     clr_we_d;
  logic              core_reset_q, core_reset_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;
  logic [NSRC:0]     cause_q,      cause_d;

  // Next-state and next-output logic; every output is computed for the
  // coming cycle so the registered outputs line up with the state register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_addr_d = '0;
    clr_we_d   = 1'b0;
    done_d     = 1'b0;
    cause_d    = cause_q;

    unique case (state_q)
      ST_CLEAR: begin
        cause_d  = cause_q | {1'b0, q};
        clr_we_d = 1'b1;
        if (any_q) begin
          // Held request pins the sweep at address 0.
          clr_addr_d = '0;
        end else if (!clr_we_q) begin
          // First cycle after async reset: the sweep starts at address 0.
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + CLR_AW'(1);
          // The edge presenting the all-ones write also enters HOLD; the
          // write itself is still on the outputs for that cycle.
          if (clr_addr_q == ADDR_PENULT) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_LOAD;
          end
        end
      end

      ST_HOLD: begin
        cause_d = cause_q | {1'b0, q};
        if (any_q) begin
          // A request beats the release, even on the cnt==0 edge.
          state_d  = ST_CLEAR;
          clr_we_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (any_q) begin
          // New sequence: the cause vector restarts from this request.
          state_d  = ST_CLEAR;
          clr_we_d = 1'b1;
          cause_d  = {1'b0, q};
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    core_reset_d = (state_d != ST_RUN);
    core_rst_n_d = (state_d == ST_RUN);
    busy_d       = (state_d != ST_RUN);
  end

  // State and output registers; async reset restarts the full sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      clr_addr_q   <= '0;
      clr_we_q     <= 1'b0;
      core_reset_q <= 1'b1;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      cause_q      <= {1'b1, {NSRC{1'b0}}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clr_addr_q   <= clr_addr_d;
      clr_we_q     <= clr_we_d;
      core_reset_q <= core_reset_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cause_q      <= cause_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign core_reset = core_reset_q;
  assign core_rst_n = core_rst_n_q;
  assign clr_addr   = clr_addr_q;
  assign clr_we     = clr_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cause      = cause_q;
  assign dbg_state  = state_q;

endmodule
